// File: rtl/ex_pkg.sv
// Shared opcode, state and width definitions for the operation sequencer.
package ex_pkg;

    localparam int RES_W = 7;

    typedef enum logic [3:0] {
        OP_MUL3  = 4'd0,
        OP_SHR3  = 4'd1,
        OP_ADD5  = 4'd2,
        OP_NAND  = 4'd3,
        OP_ROT   = 4'd4,
        OP_CAT   = 4'd5,
        OP_SEL   = 4'd6,
        OP_RANGE = 4'd7,
        OP_PAR   = 4'd8,
        OP_SWEEP = 4'd9
    } ex_op_e;

    localparam logic [3:0] SWEEP_CODE    = 4'd9;
    localparam logic [3:0] ILLEGAL_MIN   = 4'd10;
    localparam logic [3:0] LAST_SWEEP_OP = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ex_state_e;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return op >= ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Nine-function combinational datapath; all results zero-extended to RES_W bits.
module ex_alu
    import ex_pkg::*;
(
    input  logic [4:0]       p_i,
    input  logic [4:0]       q_i,
    input  logic [3:0]       op_i,
    output logic [RES_W-1:0] res_o
);

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_MUL3:  res_o = {2'b00, p_i} * 7'd3;
            OP_SHR3:  res_o = {5'b00000, q_i[4:3]};
            OP_ADD5:  res_o = {1'b0, {1'b0, p_i} + 6'd5};
            OP_NAND:  res_o = {2'b00, ~(p_i & q_i)};
            OP_ROT:   res_o = {2'b00, p_i[1:0], p_i[4:2]};
            OP_CAT:   res_o = {1'b0, p_i[2:0], q_i[4:2]};
            OP_SEL:   res_o = {2'b00, (p_i > 5'd10) ? p_i : q_i};
            OP_RANGE: res_o = {6'b000000, (q_i >= 5'd10) && (q_i <= 5'd20)};
            OP_PAR:   res_o = {6'b000000, ^p_i};
            // codes 9..15 never produce a datapath result
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_op_sequencer.sv
// Accepts one command, then streams one result beat (or nine for SWEEP) over a
// valid/ready output port, counting completed commands.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | in_ready high, waiting for a command
//   ST_EMIT | operands latched, presenting beats until the last handshake
module ex_op_sequencer
    import ex_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_p,
    input  logic [4:0]       in_q,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic [3:0]       out_op,
    output logic             out_last,
    output logic             out_err,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    ex_state_e         state_q, state_d;
    logic [4:0]        p_q, q_q;
    logic [3:0]        op_q;
    logic [3:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              last_hs;
    logic              cmd_sweep;
    logic              cmd_illegal;
    logic [3:0]        beat_op;
    logic              beat_last;
    logic [RES_W-1:0]  alu_res;

    assign accept      = in_valid && (state_q == ST_IDLE);
    assign cmd_sweep   = (op_q == SWEEP_CODE);
    assign cmd_illegal = is_illegal_op(op_q);
    // A SWEEP walks idx_q through 0..8; any other command is a single beat.
    assign beat_op     = cmd_sweep ? idx_q : op_q;
    assign beat_last   = cmd_sweep ? (idx_q == LAST_SWEEP_OP) : 1'b1;
    assign last_hs     = (state_q == ST_EMIT) && out_ready && beat_last;

    ex_alu u_alu (
        .p_i   (p_q),
        .q_i   (q_q),
        .op_i  (beat_op),
        .res_o (alu_res)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_op    = '0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_EMIT;
                    idx_d   = '0;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_op    = beat_op;
                out_last  = beat_last;
                out_err   = cmd_illegal;
                out_data  = cmd_illegal ? '0 : alu_res;
                if (out_ready) begin
                    if (beat_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Operands are captured only on acceptance, so input churn during EMIT is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q  <= '0;
            q_q  <= '0;
            op_q <= '0;
        end else if (accept) begin
            p_q  <= in_p;
            q_q  <= in_q;
            op_q <= in_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (last_hs) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done_cnt = cnt_q;

endmodule

// File: tb/tb_ex_op_sequencer.sv
// Self-checking bench: directed vector table, SWEEP/stall/reset sequences and
// randomized commands compared against an arithmetic reference model.
module tb_ex_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_p;
    logic [4:0] in_q;
    logic [3:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_data;
    logic [3:0] out_op;
    logic       out_last;
    logic       out_err;
    logic       busy;
    logic [7:0] done_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int mdl_cnt = 0;
    int obs_q[$];

    typedef struct {
        logic [3:0] op;
        int         data;
        logic       last;
        logic       err;
    } beat_t;

    typedef struct {
        logic [3:0] op;
        logic [4:0] p;
        logic [4:0] q;
        int         exp_data;
    } vec_t;

    ex_op_sequencer #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .in_q      (in_q),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_last  (out_last),
        .out_err   (out_err),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference results computed from the operation definitions with plain arithmetic.
    function automatic int ref_res(input int op, input int p, input int q);
        int ones;
        ones = 0;
        case (op)
            0: return p * 3;
            1: return q / 8;
            2: return p + 5;
            3: return 31 - (p & q);
            4: return (p % 4) * 8 + p / 4;
            5: return (p % 8) * 8 + q / 4;
            6: return (p > 10) ? p : q;
            7: return (q >= 10 && q <= 20) ? 1 : 0;
            8: begin
                for (int i = 0; i < 5; i++) ones += (p >> i) & 1;
                return ones % 2;
            end
            default: return 0;
        endcase
    endfunction

    function automatic int first_obs();
        if (obs_q.size() == 0) return -1;
        return obs_q[0];
    endfunction

    // stall_mode: 0 always ready, 1 hold ready low stall_len cycles at beat stall_beat, 2 random.
    task automatic do_cmd(input logic [3:0] op, input logic [4:0] p, input logic [4:0] q,
                          input int stall_mode, input int stall_beat, input int stall_len);
        beat_t exp[$];
        beat_t b;
        int    k, stalls, cyc;
        logic  done, r;

        exp.delete();
        if (op <= 8) begin
            b.op = op; b.data = ref_res(op, p, q); b.last = 1'b1; b.err = 1'b0;
            exp.push_back(b);
        end else if (op == 9) begin
            for (int i = 0; i < 9; i++) begin
                b.op = 4'(i); b.data = ref_res(i, p, q); b.last = (i == 8); b.err = 1'b0;
                exp.push_back(b);
            end
        end else begin
            b.op = op; b.data = 0; b.last = 1'b1; b.err = 1'b1;
            exp.push_back(b);
        end
        obs_q.delete();

        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_p = p; in_q = q;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_op = 4'($urandom); in_p = 5'($urandom); in_q = 5'($urandom);
        check("latency_valid", out_valid, 1);

        k = 0; stalls = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            if (k >= exp.size()) begin
                fail_now("extra_beat");
                done = 1'b1;
            end else begin
                check("out_valid", out_valid, 1);
                check("out_data", out_data, exp[k].data);
                check("out_op", out_op, exp[k].op);
                check("out_last", out_last, exp[k].last);
                check("out_err", out_err, exp[k].err);
                check("busy", busy, 1);
                check("in_ready_emit", in_ready, 0);
                case (stall_mode)
                    1: r = !(k == stall_beat && stalls < stall_len);
                    2: r = ($urandom_range(0, 3) != 0);
                    default: r = 1'b1;
                endcase
                if (!r) stalls++;
                out_ready = r;
                if (r && out_valid) begin
                    obs_q.push_back(int'(out_data));
                    if (exp[k].last) done = 1'b1;
                    k++;
                end
            end
            @(posedge clk); @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_op = 4'($urandom); in_p = 5'($urandom); in_q = 5'($urandom);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!done) begin
            fail_now("beat_timeout");
        end else begin
            mdl_cnt++;
            check("beats_seen", k, exp.size());
            check("post_out_valid", out_valid, 0);
            check("post_in_ready", in_ready, 1);
            check("post_busy", busy, 0);
            check("done_cnt", done_cnt, mdl_cnt & 8'hFF);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        int   sweep_exp[9];
        int   found;

        vecs[0]  = '{4'd0,  5'd31, 5'd0,  93};
        vecs[1]  = '{4'd7,  5'd0,  5'd9,  0};
        vecs[2]  = '{4'd7,  5'd0,  5'd10, 1};
        vecs[3]  = '{4'd7,  5'd0,  5'd20, 1};
        vecs[4]  = '{4'd7,  5'd0,  5'd21, 0};
        vecs[5]  = '{4'd12, 5'd17, 5'd5,  0};
        vecs[6]  = '{4'd1,  5'd0,  5'd31, 3};
        vecs[7]  = '{4'd2,  5'd31, 5'd0,  36};
        vecs[8]  = '{4'd3,  5'd0,  5'd0,  31};
        vecs[9]  = '{4'd4,  5'd1,  5'd0,  8};
        vecs[10] = '{4'd5,  5'd7,  5'd31, 63};
        vecs[11] = '{4'd6,  5'd10, 5'd3,  3};
        vecs[12] = '{4'd6,  5'd11, 5'd3,  11};
        vecs[13] = '{4'd8,  5'd7,  5'd0,  1};
        vecs[14] = '{4'd15, 5'd31, 5'd31, 0};
        sweep_exp = '{66, 1, 27, 27, 21, 51, 22, 1, 1};

        rst = 1'b1; in_valid = 1'b0; in_p = '0; in_q = '0; in_op = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_op", out_op, 0);
        check("rst_busy", busy, 0);
        check("rst_done_cnt", done_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 15; i++) begin
            do_cmd(vecs[i].op, vecs[i].p, vecs[i].q, 0, 0, 0);
            check($sformatf("vec%0d_data", i), first_obs(), vecs[i].exp_data);
        end

        do_cmd(4'd9, 5'd22, 5'd13, 0, 0, 0);
        check("sweep_count", obs_q.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < obs_q.size()) check($sformatf("sweep_beat%0d", i), obs_q[i], sweep_exp[i]);

        do_cmd(4'd9, 5'd22, 5'd13, 1, 2, 3);
        check("stall_count", obs_q.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < obs_q.size()) check($sformatf("stall_beat%0d", i), obs_q[i], sweep_exp[i]);

        for (int n = 0; n < 300; n++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 5) == 0) ? 4'd9 : 4'($urandom);
            do_cmd(rop, 5'($urandom), 5'($urandom), 2, 0, 0);
        end

        check("in_ready_before_rst", in_ready, 1);
        in_valid = 1'b1; in_op = 4'd9; in_p = 5'd22; in_q = 5'd13;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (out_valid && out_op == 4'd4) found = 1;
            else begin
                @(posedge clk); @(negedge clk);
            end
        end
        if (found == 0) fail_now("reach_beat4");
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_done_cnt", done_cnt, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0; mdl_cnt = 0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        do_cmd(4'd0, 5'd1, 5'd0, 0, 0, 0);
        check("post_rst_op0", first_obs(), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
